// File: rtl/riscv_mc_controller.sv
// Multicycle main controller for the RV32 shared-memory datapath.
// Moore FSM with memory wait states, ALU/immediate decode and a sticky trap state.
module riscv_mc_controller #(
   parameter int unsigned WAIT_EN = 1,
   parameter int unsigned STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal_instr,
   output logic [3:0] state_o
);

   typedef enum logic [STATE_W-1:0] {
      StFetch    = STATE_W'(0),
      StDecode   = STATE_W'(1),
      StMemAdr   = STATE_W'(2),
      StMemRead  = STATE_W'(3),
      StMemWb    = STATE_W'(4),
      StMemWrite = STATE_W'(5),
      StExecR    = STATE_W'(6),
      StAluWb    = STATE_W'(7),
      StExecI    = STATE_W'(8),
      StJal      = STATE_W'(9),
      StBeq      = STATE_W'(10),
      StTrap     = STATE_W'(11)
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   state_e     state_q, state_d;
   logic       ready;
   logic       arith_f3_ok;
   logic       pc_update;
   logic       branch;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;

   assign ready = (WAIT_EN == 0) ? 1'b1 : mem_ready;

   // Only add/sub, slt, or and and are implemented for R/I arithmetic.
   assign arith_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      case (state_q)
         StFetch: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = ready;
            pc_update  = ready;
            if (ready) begin
               state_d = StDecode;
            end
         end
         StDecode: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = arith_f3_ok ? StExecR : StTrap;
               OpIType:         state_d = arith_f3_ok ? StExecI : StTrap;
               OpJal:           state_d = StJal;
               OpBranch:        state_d = (funct3 == 3'b000) ? StBeq : StTrap;
               default:         state_d = StTrap;
            endcase
         end
         StMemAdr: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (op == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            adr_src = 1'b1;
            if (ready) begin
               state_d = StMemWb;
            end
         end
         StMemWb: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (ready) begin
               state_d = StFetch;
            end
         end
         StExecR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = StAluWb;
         end
         StExecI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StJal: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_d   = StAluWb;
         end
         StBeq: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            state_d   = StFetch;
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OpStore:  ImmSrc = 2'b01;
         OpBranch: ImmSrc = 2'b10;
         OpJal:    ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

   // Enables are masked by reset directly so they drop without waiting for an edge.
   assign PCWrite       = reset & (pc_update | (branch & Zero));
   assign IRWrite       = reset & ir_write;
   assign MemWrite      = reset & mem_write;
   assign RegWrite      = reset & reg_write;
   assign illegal_instr = reset & (state_q == StTrap);
   assign AdrSrc        = adr_src;
   assign ResultSrc     = result_src;
   assign ALUSrcA       = alu_src_a;
   assign ALUSrcB       = alu_src_b;
   assign state_o       = 4'(state_q);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench: per-instruction state traces built from the instruction rules,
// every cycle compared against a behavioural output model.
module tb_riscv_mc_controller;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                          S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_ALUWB = 4'd7,
                          S_EXECI = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10, S_TRAP = 4'd11;
   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_o;

   int vectors = 0;
   int miscompares = 0;
   int zero_mode = 2;

   typedef struct packed {
      logic [3:0] st;
      logic       rdy;
   } step_t;
   step_t plan[$];

   riscv_mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .illegal_instr(illegal_instr), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Expected {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
   // RegWrite, ImmSrc, ALUControl, illegal_instr}.
   function automatic logic [20:0] model(input logic [3:0] st, input logic rdy, input logic rst_n,
                                         input logic z, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
      logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0, imm = 0;
      logic [2:0] alu = 3'b000;
      logic [2:0] arith;
      if (f3 == 3'b000)      arith = (o == RT && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) arith = 3'b101;
      else if (f3 == 3'b110) arith = 3'b011;
      else                   arith = 3'b010;
      imm = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
      case (st)
         S_FETCH:    begin sb = 2; rs = 2; pcw = rdy; irw = rdy; end
         S_DECODE:   begin sa = 1; sb = 1; end
         S_MEMADR:   begin sa = 2; sb = 1; end
         S_MEMREAD:  adr = 1;
         S_MEMWB:    begin rs = 1; rw = 1; end
         S_MEMWRITE: begin adr = 1; mw = 1; end
         S_EXECR:    begin sa = 2; alu = arith; end
         S_ALUWB:    rw = 1;
         S_EXECI:    begin sa = 2; sb = 1; alu = arith; end
         S_JAL:      begin sa = 1; sb = 2; pcw = 1; end
         S_BEQ:      begin sa = 2; alu = 3'b001; pcw = z; end
         default:    ill = 1;
      endcase
      if (!rst_n) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
      return {st, pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill};
   endfunction

   task automatic check(input string tag, input logic [3:0] st, input logic rdy);
      logic [20:0] exp_v, obs_v;
      exp_v = model(st, rdy, reset, Zero, op, funct3, funct7b5);
      obs_v = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal_instr};
      vectors++;
      assert (obs_v === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h (state obs=%0d exp=%0d)",
                tag, obs_v, exp_v, state_o, st);
      end
   endtask

   task automatic add(input logic [3:0] st);
      plan.push_back('{st: st, rdy: 1'($urandom_range(1, 0))});
   endtask

   task automatic add_wait(input logic [3:0] st, input int w);
      for (int i = 0; i < w; i++) plan.push_back('{st: st, rdy: 1'b0});
      plan.push_back('{st: st, rdy: 1'b1});
   endtask

   task automatic play(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7);
      foreach (plan[i]) begin
         @(negedge clk);
         op = o; funct3 = f3; funct7b5 = f7;
         mem_ready = plan[i].rdy;
         Zero = (zero_mode == 2) ? 1'($urandom_range(1, 0)) : zero_mode[0];
         #1 check(tag, plan[i].st, plan[i].rdy);
      end
      plan.delete();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1;
      #1 check(tag, S_FETCH, 1'b1);
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b0;
      #1 check(tag, S_FETCH, 1'b0);
   endtask

   initial begin
      logic [2:0] legal[4];
      logic [2:0] bad[4];
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7;
      int         k, wf, trapped;
      legal = '{3'b000, 3'b010, 3'b110, 3'b111};
      bad   = '{3'b001, 3'b011, 3'b100, 3'b101};
      reset = 1'b1;
      #1 reset = 1'b0;
      do_reset("reset_state");

      // sw stalled in MEMWRITE, then reset mid-cycle
      add_wait(S_FETCH, 0); add(S_DECODE); add(S_MEMADR);
      plan.push_back('{st: S_MEMWRITE, rdy: 1'b0}); plan.push_back('{st: S_MEMWRITE, rdy: 1'b0});
      play("sw_stall", SW, 3'b010, 1'b0);
      #1 reset = 1'b0;
      #1 check("async_reset_memwrite", S_FETCH, 1'b0);
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      @(posedge clk);
      #1 check("post_reset_decode", S_DECODE, 1'b1);
      do_reset("reset2");

      add_wait(S_FETCH, 0); add(S_DECODE); add(S_EXECR); add(S_ALUWB);
      play("r_sub", RT, 3'b000, 1'b1);
      add_wait(S_FETCH, 0); add(S_DECODE); add(S_MEMADR); add_wait(S_MEMREAD, 2); add(S_MEMWB);
      play("lw_wait", LW, 3'b010, 1'b0);
      zero_mode = 1;
      add_wait(S_FETCH, 0); add(S_DECODE); add(S_BEQ);
      play("beq_taken", BEQ, 3'b000, 1'b0);
      zero_mode = 0;
      add_wait(S_FETCH, 0); add(S_DECODE); add(S_BEQ);
      play("beq_not_taken", BEQ, 3'b000, 1'b0);
      zero_mode = 2;
      add_wait(S_FETCH, 0); add(S_DECODE); add(S_JAL); add(S_ALUWB);
      play("jal", JAL, 3'b000, 1'b0);
      add_wait(S_FETCH, 0); add(S_DECODE);
      for (int i = 0; i < 20; i++) add(S_TRAP);
      play("trap", 7'b1111111, 3'b000, 1'b0);
      do_reset("trap_clear");

      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(9, 0);
         wf = $urandom_range(2, 0);
         f7 = 1'($urandom_range(1, 0));
         f3 = legal[$urandom_range(3, 0)];
         trapped = 0;
         add_wait(S_FETCH, wf); add(S_DECODE);
         case (k)
            0: begin o = LW; add(S_MEMADR); add_wait(S_MEMREAD, $urandom_range(2, 0)); add(S_MEMWB); end
            1: begin o = SW; add(S_MEMADR); add_wait(S_MEMWRITE, $urandom_range(2, 0)); end
            2, 3: begin o = RT; add(S_EXECR); add(S_ALUWB); end
            4, 5: begin o = IT; add(S_EXECI); add(S_ALUWB); end
            6: begin o = JAL; add(S_JAL); add(S_ALUWB); end
            7: begin o = BEQ; f3 = 3'b000; add(S_BEQ); end
            default: begin
               trapped = 1;
               case ($urandom_range(3, 0))
                  0: o = 7'b1111111;
                  1: begin o = RT; f3 = bad[$urandom_range(3, 0)]; end
                  2: begin o = IT; f3 = bad[$urandom_range(3, 0)]; end
                  default: begin o = BEQ; f3 = 3'($urandom_range(7, 1)); end
               endcase
               for (int i = 0; i < 3; i++) add(S_TRAP);
            end
         endcase
         play("random", o, f3, f7);
         if (trapped != 0) do_reset("random_trap_clear");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Multicycle main controller FSM for the RV32 core; sequences a shared-memory multicycle datapath (single memory for instruction and data, non-architectural IR/Data/ALUOut registers).
- Decodes op/funct3/funct7b5 and emits per-state mux selects and write enables.
- Inserts wait states on memory via mem_ready.
- Traps on unsupported instructions.

Parameters:
- WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
- STATE_W, 4, state register width. Fixed; must be at least 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op  input  7  Instr[6:0] from IR.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR and OldPC load enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = Imm, 10 = constant 4.
- RegWrite  output  1  register file write enable.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_instr  output  1  sticky trap flag.
- state_o  output  4  current state, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11
  - Codes 12–15 are unreachable; if entered, go to FETCH.
- Reset:
  - reset=0 forces state to FETCH asynchronously.
  - While reset is low, PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr are 0; the remaining outputs take FETCH values.
- Outputs are Moore, decoded from state, except:
  - PCWrite = PCUpdate | (Branch & Zero).
  - mem_ready gating in FETCH.
  - ImmSrc and ALUControl, which are also decoded from op/funct3/funct7b5.
- Unlisted outputs are 0 in every state.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite and PCUpdate = mem_ready. Go to DECODE when mem_ready, otherwise stay.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 with funct3=000 -> BEQ
    - anything else -> TRAP
    - R/I op with funct3 outside {000, 010, 110, 111} -> TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB when mem_ready, otherwise stay.
  - MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held until mem_ready; go to FETCH when mem_ready.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next is ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next is FETCH.
  - TRAP: all enables 0, illegal_instr=1. Stays in TRAP until reset.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct3:
    - 000 -> sub if op[5] & funct7b5, else add.
    - 010 -> slt.
    - 110 -> or.
    - 111 -> and.
- ImmSrc by op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
- Latency with zero wait states:
  - beq 3 cycles.
  - R, I, jal and sw 4 cycles.
  - lw 5 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset low mid-MEMWRITE with MemWrite=1 -> MemWrite drops to 0 immediately, without waiting for a clock edge. After release, the first edge with mem_ready=1 -> state DECODE.
- R-type sub (op=0110011, funct3=000, funct7b5=1), mem_ready=1 -> states 0,1,6,7,0; ALUControl=001 in EXECUTER; RegWrite=1 only in ALUWB.
- lw with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; AdrSrc=1 throughout MEMREAD; RegWrite=1 in MEMWB.
- beq:
  - Zero=1 in BEQ -> PCWrite=1 for that one cycle.
  - Zero=0 -> PCWrite=0.
  - Both cases -> 3-cycle instruction.
- op=1111111 -> TRAP after DECODE; illegal_instr=1 and all enables 0 for 20 cycles; reset clears it.
- jal -> states 0,1,9,7,0; PCWrite=1 in JAL; ImmSrc=11.
